// File: rtl/rom_arb_pkg.sv
// Shared definitions for the character/bitmap ROM arbiter and the display
// control logic that sits beside it: default geometry, burst-counter width,
// the read-owner tag and the fixed-priority arbitration rule.
package rom_arb_pkg;

    // Default ROM geometry: 128 rows of 16-pixel bitmap data.
    localparam int ROM_ADDR_W    = 7;
    localparam int ROM_DATA_W    = 16;

    // Default number of consecutive display grants a waiting background
    // port tolerates before it is forced through.
    localparam int MAX_BURST_DEF = 8;

    // Burst counter width; holds any burst limit in 1..15.
    localparam int BURST_CNT_W   = 4;

    // Which port owns the ROM slot being arbitrated this cycle.
    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_P0   = 2'd1,
        OWNER_P1   = 2'd2
    } owner_e;

    // Display port has priority unless the background port has already
    // waited out a full burst; a lone requester always wins.
    function automatic owner_e arbitrate(input logic r0,
                                         input logic r1,
                                         input logic burst_full);
        owner_e winner;
        winner = OWNER_NONE;
        if (r0 && r1) begin
            winner = burst_full ? OWNER_P1 : OWNER_P0;
        end else if (r0) begin
            winner = OWNER_P0;
        end else if (r1) begin
            winner = OWNER_P1;
        end
        return winner;
    endfunction

endpackage

// File: rtl/rom_share_arbiter.sv
// Two-port front end for a single-port, registered-output bitmap ROM.
// Port 0 (display) has priority; port 1 (loader/checker) is guaranteed a
// slot after at most MAX_BURST consecutive port-0 grants. One read is issued
// per cycle and its data is steered back to the issuing port one cycle after
// the grant.
//
// Handshake: a port holds reqX high for as long as it wants reads. gntX high
// in a cycle means the address that was on addrX at the preceding rising
// edge has been issued to the ROM; that read can no longer be withdrawn.
// rdataX_valid rises exactly one cycle after gntX, with rdataX carrying the
// ROM word; rdataX is zero whenever rdataX_valid is low. There is no
// back-pressure on the return path.
module rom_share_arbiter
    import rom_arb_pkg::*;
#(
    parameter int ADDR_W    = ROM_ADDR_W,
    parameter int DATA_W    = ROM_DATA_W,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic              vga_clk,
    input  logic              rst_n,

    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rdata0_valid,
    output logic [DATA_W-1:0] rdata0,

    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rdata1_valid,
    output logic [DATA_W-1:0] rdata1,

    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    // Burst limit in counter width; MAX_BURST is expected in 1..15.
    localparam logic [BURST_CNT_W-1:0] BURST_LIMIT = BURST_CNT_W'(MAX_BURST);

    logic [BURST_CNT_W-1:0] burst_cnt;
    logic                   burst_full;
    owner_e                 winner;

    // Arbitration decision for the coming edge, from live requests and the
    // current burst count.
    always_comb begin
        burst_full = (burst_cnt == BURST_LIMIT);
        winner     = arbitrate(req0, req1, burst_full);
    end

    // Grant, ROM address and burst tracking. The winner's address is latched
    // here, so later changes on addrX cannot disturb an issued read. With no
    // winner the ROM address simply holds.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            rom_addr  <= '0;
            burst_cnt <= '0;
        end else begin
            gnt0 <= (winner == OWNER_P0);
            gnt1 <= (winner == OWNER_P1);

            if (winner == OWNER_P0) begin
                rom_addr <= addr0;
            end else if (winner == OWNER_P1) begin
                rom_addr <= addr1;
            end

            // Count only display grants that made port 1 wait; any port-1
            // grant or a withdrawn port-1 request starts the count afresh.
            if (!req1 || (winner == OWNER_P1)) begin
                burst_cnt <= '0;
            end else if ((winner == OWNER_P0) && !burst_full) begin
                burst_cnt <= burst_cnt + BURST_CNT_W'(1);
            end
        end
    end

    // Read-return pipeline: the registered grant pair is the owner tag of
    // the read the ROM is answering now, so each valid follows its grant by
    // exactly one cycle. Reset discards any read still in flight.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_valid <= 1'b0;
            rdata1_valid <= 1'b0;
        end else begin
            rdata0_valid <= gnt0;
            rdata1_valid <= gnt1;
        end
    end

    // Steer ROM output to the owning port; the other port sees zeros.
    always_comb begin
        rdata0 = rdata0_valid ? rom_data : '0;
        rdata1 = rdata1_valid ? rom_data : '0;
    end

endmodule

// File: tb/tb_rom_share_arbiter.sv
// Directed bench for rom_share_arbiter. Two instances share the request
// inputs: dut_a uses the default burst limit of 8, dut_b a limit of 1. Each
// has its own registered-output ROM model with a known content function.
module tb_rom_share_arbiter;

    logic        vga_clk;
    logic        rst_n;
    logic        req0;
    logic [6:0]  addr0;
    logic        req1;
    logic [6:0]  addr1;

    logic        a_gnt0, a_gnt1, a_v0, a_v1;
    logic [15:0] a_d0, a_d1, a_rom_data;
    logic [6:0]  a_rom_addr;

    logic        b_gnt0, b_gnt1, b_v0, b_v1;
    logic [15:0] b_d0, b_d1, b_rom_data;
    logic [6:0]  b_rom_addr;

    int checks;
    int failures;

    // ROM contents: row 16 is a marker pattern, the rest are distinct values.
    function automatic logic [15:0] rom_val(input int a);
        if (a == 16) return 16'h8001;
        return 16'h4000 | 16'(a * 37);
    endfunction

    rom_share_arbiter #(.ADDR_W(7), .DATA_W(16), .MAX_BURST(8)) dut_a (
        .vga_clk(vga_clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(a_gnt0),
        .rdata0_valid(a_v0), .rdata0(a_d0),
        .req1(req1), .addr1(addr1), .gnt1(a_gnt1),
        .rdata1_valid(a_v1), .rdata1(a_d1),
        .rom_addr(a_rom_addr), .rom_data(a_rom_data)
    );

    rom_share_arbiter #(.ADDR_W(7), .DATA_W(16), .MAX_BURST(1)) dut_b (
        .vga_clk(vga_clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(b_gnt0),
        .rdata0_valid(b_v0), .rdata0(b_d0),
        .req1(req1), .addr1(addr1), .gnt1(b_gnt1),
        .rdata1_valid(b_v1), .rdata1(b_d1),
        .rom_addr(b_rom_addr), .rom_data(b_rom_data)
    );

    // Clock
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // Registered-output ROM models
    always @(posedge vga_clk) begin
        a_rom_data <= rom_val(int'(a_rom_addr));
        b_rom_data <= rom_val(int'(b_rom_addr));
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge vga_clk);
        #1;
    endtask

    task automatic drain;
        req0 = 1'b0;
        req1 = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        addr0 = '0;
        addr1 = '0;
        tick;
        tick;
        checks++;
        if ({a_gnt0, a_gnt1, a_v0, a_v1} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_a_flags got=%b exp=0000", {a_gnt0, a_gnt1, a_v0, a_v1});
        end
        checks++;
        if ({a_d0, a_d1} !== 32'h0) begin
            failures++;
            $display("FAIL reset_a_rdata got=%h exp=00000000", {a_d0, a_d1});
        end
        checks++;
        if (a_rom_addr !== 7'd0) begin
            failures++;
            $display("FAIL reset_a_rom_addr got=%0d exp=0", a_rom_addr);
        end
        checks++;
        if ({b_gnt0, b_gnt1, b_v0, b_v1, b_rom_addr} !== 11'd0) begin
            failures++;
            $display("FAIL reset_b_outputs got=%b exp=0", {b_gnt0, b_gnt1, b_v0, b_v1, b_rom_addr});
        end
        // Request waiting at release must be granted on the first edge.
        req0  = 1'b1;
        addr0 = 7'd9;
        @(negedge vga_clk);
        rst_n = 1'b1;
        tick;
        req0 = 1'b0;
        @(negedge vga_clk);
        checks++;
        if (a_gnt0 !== 1'b1 || a_rom_addr !== 7'd9) begin
            failures++;
            $display("FAIL first_edge_grant got=gnt0:%b addr:%0d exp=gnt0:1 addr:9", a_gnt0, a_rom_addr);
        end
        tick;
        @(negedge vga_clk);
        checks++;
        if (a_v0 !== 1'b1 || a_d0 !== rom_val(9) || a_gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL first_edge_data got=v:%b d:%h g:%b exp=v:1 d:%h g:0", a_v0, a_d0, a_gnt0, rom_val(9));
        end
        drain;
    endtask

    task automatic test_port0_stream;
        int k;
        for (int i = 0; i < 22; i++) begin
            tick;
            req1  = 1'b0;
            req0  = (i < 20);
            addr0 = 7'(i);
            @(negedge vga_clk);
            k = i - 1;
            checks++;
            if (a_gnt0 !== ((k >= 0) && (k < 20)) || a_gnt1 !== 1'b0) begin
                failures++;
                $display("FAIL p0_stream_gnt i=%0d got=%b%b exp=%b0", i, a_gnt0, a_gnt1, (k >= 0) && (k < 20));
            end
            if (k >= 0) begin
                checks++;
                if (a_rom_addr !== 7'((k < 20) ? k : 19)) begin
                    failures++;
                    $display("FAIL p0_stream_addr i=%0d got=%0d exp=%0d", i, a_rom_addr, (k < 20) ? k : 19);
                end
            end
            k = i - 2;
            if (k >= 0 && k < 20) begin
                checks++;
                if (a_v0 !== 1'b1 || a_d0 !== rom_val(k)) begin
                    failures++;
                    $display("FAIL p0_stream_data i=%0d got=v:%b d:%h exp=v:1 d:%h", i, a_v0, a_d0, rom_val(k));
                end
            end else begin
                checks++;
                if (a_v0 !== 1'b0 || a_d0 !== 16'h0) begin
                    failures++;
                    $display("FAIL p0_stream_idle i=%0d got=v:%b d:%h exp=v:0 d:0000", i, a_v0, a_d0);
                end
            end
            checks++;
            if (a_v1 !== 1'b0 || a_d1 !== 16'h0) begin
                failures++;
                $display("FAIL p0_stream_p1_quiet i=%0d got=v:%b d:%h exp=v:0 d:0000", i, a_v1, a_d1);
            end
        end
        drain;
    endtask

    task automatic test_port1_alone;
        tick;
        req1  = 1'b1;
        addr1 = 7'd16;
        tick;
        // Drop the request and move the address in the granted cycle.
        req1  = 1'b0;
        addr1 = 7'd5;
        @(negedge vga_clk);
        checks++;
        if (a_gnt1 !== 1'b1 || a_gnt0 !== 1'b0 || a_rom_addr !== 7'd16) begin
            failures++;
            $display("FAIL p1_alone_gnt got=g1:%b g0:%b addr:%0d exp=g1:1 g0:0 addr:16", a_gnt1, a_gnt0, a_rom_addr);
        end
        tick;
        @(negedge vga_clk);
        checks++;
        if (a_v1 !== 1'b1 || a_d1 !== 16'h8001) begin
            failures++;
            $display("FAIL p1_alone_data got=v:%b d:%h exp=v:1 d:8001", a_v1, a_d1);
        end
        checks++;
        if (a_v0 !== 1'b0 || a_d0 !== 16'h0 || a_gnt1 !== 1'b0) begin
            failures++;
            $display("FAIL p1_alone_p0_zero got=v0:%b d0:%h g1:%b exp=v0:0 d0:0000 g1:0", a_v0, a_d0, a_gnt1);
        end
        checks++;
        if (a_rom_addr !== 7'd16) begin
            failures++;
            $display("FAIL p1_alone_addr_hold got=%0d exp=16", a_rom_addr);
        end
        tick;
        @(negedge vga_clk);
        checks++;
        if (a_v1 !== 1'b0 || a_d1 !== 16'h0) begin
            failures++;
            $display("FAIL p1_alone_after got=v:%b d:%h exp=v:0 d:0000", a_v1, a_d1);
        end
        drain;
    endtask

    // Both ports held: dut_a grants 8x port 0 then 1x port 1, dut_b alternates.
    task automatic test_both_held;
        int   k;
        logic pa, pb;
        logic [6:0] ea, eb;
        for (int i = 0; i < 29; i++) begin
            tick;
            req0  = (i < 27);
            req1  = (i < 27);
            addr0 = 7'(32 + i);
            addr1 = 7'(64 + i);
            @(negedge vga_clk);
            k = i - 1;
            if (k >= 0 && k < 27) begin
                pa = (k % 9 == 8);
                pb = (k % 2 == 1);
                ea = pa ? 7'(64 + k) : 7'(32 + k);
                eb = pb ? 7'(64 + k) : 7'(32 + k);
                checks++;
                if (a_gnt0 !== !pa || a_gnt1 !== pa || a_rom_addr !== ea) begin
                    failures++;
                    $display("FAIL burst8_gnt k=%0d got=g0:%b g1:%b a:%0d exp=g0:%b g1:%b a:%0d", k, a_gnt0, a_gnt1, a_rom_addr, !pa, pa, ea);
                end
                checks++;
                if (b_gnt0 !== !pb || b_gnt1 !== pb || b_rom_addr !== eb) begin
                    failures++;
                    $display("FAIL burst1_gnt k=%0d got=g0:%b g1:%b a:%0d exp=g0:%b g1:%b a:%0d", k, b_gnt0, b_gnt1, b_rom_addr, !pb, pb, eb);
                end
            end else begin
                checks++;
                if ({a_gnt0, a_gnt1, b_gnt0, b_gnt1} !== 4'b0000) begin
                    failures++;
                    $display("FAIL both_idle_gnt i=%0d got=%b exp=0000", i, {a_gnt0, a_gnt1, b_gnt0, b_gnt1});
                end
            end
            k = i - 2;
            if (k >= 0 && k < 27) begin
                pa = (k % 9 == 8);
                pb = (k % 2 == 1);
                ea = pa ? 7'(64 + k) : 7'(32 + k);
                eb = pb ? 7'(64 + k) : 7'(32 + k);
                checks++;
                if (a_v0 !== !pa || a_v1 !== pa ||
                    a_d0 !== (pa ? 16'h0 : rom_val(int'(ea))) ||
                    a_d1 !== (pa ? rom_val(int'(ea)) : 16'h0)) begin
                    failures++;
                    $display("FAIL burst8_data k=%0d got=v0:%b v1:%b d0:%h d1:%h exp_owner_p1=%b d=%h", k, a_v0, a_v1, a_d0, a_d1, pa, rom_val(int'(ea)));
                end
                checks++;
                if (b_v0 !== !pb || b_v1 !== pb ||
                    b_d0 !== (pb ? 16'h0 : rom_val(int'(eb))) ||
                    b_d1 !== (pb ? rom_val(int'(eb)) : 16'h0)) begin
                    failures++;
                    $display("FAIL burst1_data k=%0d got=v0:%b v1:%b d0:%h d1:%h exp_owner_p1=%b d=%h", k, b_v0, b_v1, b_d0, b_d1, pb, rom_val(int'(eb)));
                end
            end else begin
                checks++;
                if ({a_v0, a_v1, b_v0, b_v1} !== 4'b0000) begin
                    failures++;
                    $display("FAIL both_idle_valid i=%0d got=%b exp=0000", i, {a_v0, a_v1, b_v0, b_v1});
                end
            end
        end
        drain;
    endtask

    // req1 withdrawn after 5 waiting grants: the count restarts, so port 1
    // needs a fresh run of 8 port-0 grants (edges 6..13) before edge 14.
    task automatic test_burst_restart;
        int   k;
        logic p1;
        for (int i = 0; i < 17; i++) begin
            tick;
            req0  = (i < 16);
            req1  = (i < 16) && (i != 5);
            addr0 = 7'(i);
            addr1 = 7'(100 + i);
            @(negedge vga_clk);
            k = i - 1;
            if (k >= 0 && k < 16) begin
                p1 = (k == 14);
                checks++;
                if (a_gnt0 !== !p1 || a_gnt1 !== p1 ||
                    a_rom_addr !== (p1 ? 7'(100 + k) : 7'(k))) begin
                    failures++;
                    $display("FAIL restart_gnt k=%0d got=g0:%b g1:%b a:%0d exp=g0:%b g1:%b", k, a_gnt0, a_gnt1, a_rom_addr, !p1, p1);
                end
            end
        end
        drain;
    endtask

    task automatic test_reset_inflight;
        tick;
        req0  = 1'b1;
        addr0 = 7'd3;
        tick;
        req0 = 1'b0;
        checks++;
        if (a_gnt0 !== 1'b1 || a_rom_addr !== 7'd3) begin
            failures++;
            $display("FAIL inflight_gnt got=g0:%b a:%0d exp=g0:1 a:3", a_gnt0, a_rom_addr);
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_gnt0, a_gnt1, a_v0, a_v1, a_rom_addr} !== 11'd0 || {a_d0, a_d1} !== 32'h0) begin
            failures++;
            $display("FAIL inflight_reset_zero got=%b d=%h exp=0", {a_gnt0, a_gnt1, a_v0, a_v1, a_rom_addr}, {a_d0, a_d1});
        end
        @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n = 1'b1;
        tick;
        checks++;
        if (a_v0 !== 1'b0 || a_d0 !== 16'h0 || a_gnt0 !== 1'b0) begin
            failures++;
            $display("FAIL inflight_dropped got=v:%b d:%h g:%b exp=v:0 d:0000 g:0", a_v0, a_d0, a_gnt0);
        end
        req0  = 1'b1;
        addr0 = 7'd7;
        tick;
        req0 = 1'b0;
        checks++;
        if (a_gnt0 !== 1'b1 || a_rom_addr !== 7'd7 || a_v0 !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_gnt got=g:%b a:%0d v:%b exp=g:1 a:7 v:0", a_gnt0, a_rom_addr, a_v0);
        end
        tick;
        checks++;
        if (a_v0 !== 1'b1 || a_d0 !== rom_val(7)) begin
            failures++;
            $display("FAIL post_reset_data got=v:%b d:%h exp=v:1 d:%h", a_v0, a_d0, rom_val(7));
        end
        drain;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset;
        test_port0_stream;
        test_port1_alone;
        test_both_held;
        test_burst_restart;
        test_reset_inflight;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rom_share_arbiter.md
ROM_SHARE_ARBITER -- requirements
Module: rom_share_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7: ROM address width.
REQ-002 Parameter DATA_W, default 16: ROM data width; one bitmap row per word.
REQ-003 Parameter MAX_BURST, default 8: max consecutive port-0 grants while port 1 waits; legal range 1..15.
REQ-004 vga_clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req0  input  1  port 0 (display) read request; high-priority port.
REQ-007 addr0  input  ADDR_W  port 0 read address.
REQ-008 gnt0  output  1  port 0 granted this cycle (registered).
REQ-009 rdata0_valid  output  1  port 0 read data valid this cycle (registered).
REQ-010 rdata0  output  DATA_W  port 0 read data.
REQ-011 req1, addr1, gnt1, rdata1_valid, rdata1: same as REQ-006..REQ-010 for port 1 (background: loader/checker).
REQ-012 rom_addr  output  ADDR_W  address to shared single-port ROM (registered).
REQ-013 rom_data  input  DATA_W  ROM output; valid one cycle after rom_addr presented (registered-output ROM).

Function
REQ-014 The block shall grant at most one port per cycle; gnt0 and gnt1 never high together.
REQ-015 On each rising edge, arbitration shall use sampled req0/req1 and burst counter; winner's gnt and rom_addr (its address) become valid after that edge.
REQ-016 Arbitration rule: only one requesting -> it wins; both requesting -> port 0 wins unless burst counter == MAX_BURST, then port 1 wins; neither -> no grant.
REQ-017 Burst counter (4 bits) shall increment on each port-0 grant made while req1 was sampled high, clear on any port-1 grant, clear when req1 sampled low; it shall never exceed MAX_BURST.
REQ-018 A request held high shall receive back-to-back grants per REQ-016; each grant consumes exactly one read; address captured at grant edge, later addr changes not affecting that read.
REQ-019 rdataX_valid shall be high exactly in the cycle after gntX high (1-cycle latency gnt->data, 2 cycles req-sample->data).
REQ-020 rdataX shall equal rom_data when rdataX_valid high, else all zeros.
REQ-021 With no grant, rom_addr shall hold its last value; gnt0/gnt1 low.
REQ-022 Back-to-back grants alternating ports shall each return correct data to the correct port with no bubble (full throughput, 1 read/cycle).
REQ-023 Deasserting a request in the same cycle it is granted shall not cancel that read; its data still returns per REQ-019.

Reset
REQ-024 While rst_n low: gnt0, gnt1, rdata0_valid, rdata1_valid = 0; rdata0, rdata1 = 0; rom_addr = 0; burst counter = 0.
REQ-025 Reset asserted mid-operation shall drop in-flight reads; no rdata_valid after reset release until a new grant.
REQ-026 First edge after rst_n rises shall arbitrate normally (grant possible on that edge).

Structure
REQ-027 ADDR_W, DATA_W, MAX_BURST defaults and burst-counter width shall live in shared package rom_arb_pkg, shared with the display control module.
REQ-028 Single module; no sub-module; read-return pipeline (1 stage, owner tag) inline.

Verification
REQ-029 Only req0 held 20 cycles, addr0 = 0..19 -> gnt0 every cycle, rdata0 = ROM[n] one cycle after each grant, gnt1 never high.
REQ-030 req0 and req1 both held, MAX_BURST = 8 -> grant pattern 8x port 0, 1x port 1, repeating; port-1 data = ROM[addr1] with correct timing.
REQ-031 MAX_BURST = 1, both held -> strict alternation 0,1,0,1; no cycle without grant.
REQ-032 req1 alone, addr1 = 16, ROM[16] = 16'h8001 -> gnt1 after first edge, rdata1 = 16'h8001 and rdata1_valid next cycle, rdata0 = 0.
REQ-033 rst_n pulsed low while port-0 read in flight -> all outputs zero immediately, no rdata0_valid after release, next request served normally.
REQ-034 req1 drops while burst counter = 5, then reasserts -> counter restarts at 0; port 1 waits full 8 port-0 grants.
